// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for RV32 branch units:
//   - br_funct3_e : funct3 encodings of the conditional branches
//                   (BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU)
//   - idx_width()         : number of index bits needed for a table size
//   - ctr_reset_value()   : weakly-not-taken value of a saturating counter
// -----------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  // Ceiling log2 for table sizes; callers guarantee entries >= 2.
  function automatic int idx_width(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < entries) w++;
    end
    return w;
  endfunction

  // Weakly-not-taken: the largest value whose MSB is still 0.
  function automatic int ctr_reset_value(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational RV32 branch-condition evaluator.
// Ports:
//   funct3_i        branch funct3
//   zero_flag_i     ALU zero
//   sign_flag_i     ALU sign
//   carry_flag_i    ALU borrow (unsigned less-than)
//   overflow_flag_i ALU signed overflow
//   taken_o         branch condition holds (0 for illegal encodings)
//   illegal_o       funct3 is 010 or 011
// -----------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_flag_i,
  input  logic       sign_flag_i,
  input  logic       carry_flag_i,
  input  logic       overflow_flag_i,
  output logic       taken_o,
  output logic       illegal_o
);

  logic w_lt_signed;

  // Signed less-than is sign corrected by overflow.
  assign w_lt_signed = sign_flag_i ^ overflow_flag_i;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  taken_o = zero_flag_i;
      BR_BNE:  taken_o = ~zero_flag_i;
      BR_BLT:  taken_o = w_lt_signed;
      BR_BGE:  taken_o = ~w_lt_signed;
      BR_BLTU: taken_o = carry_flag_i;
      BR_BGEU: taken_o = ~carry_flag_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// -----------------------------------------------------------------------------
// branch_resolve_predict
// Branch unit: resolves RV32 conditional branches from ALU flags, trains a
// bimodal table of saturating counters, serves a registered prediction lookup
// and counts resolved / mispredicted branches.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   pred_valid_i, pred_pc_i            fetch lookup request
//   pred_valid_o, pred_taken_o         lookup result (1 cycle later)
//   res_valid_i, res_pc_i,
//   res_funct3_i, res_pred_taken_i     resolving branch from execute
//   zero/sign/carry/overflow_flag_i    ALU flags for the resolving branch
//   res_valid_o, res_taken_o,
//   res_mispredict_o, res_illegal_o    resolve result pulses (1 cycle later)
//   branch_cnt_o, mispredict_cnt_o     wrap-around performance counters
// -----------------------------------------------------------------------------
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int PC_WIDTH    = 32,
  parameter int PC_LSB      = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pred_valid_i,
  input  logic [PC_WIDTH-1:0]  pred_pc_i,
  output logic                 pred_valid_o,
  output logic                 pred_taken_o,
  input  logic                 res_valid_i,
  input  logic [PC_WIDTH-1:0]  res_pc_i,
  input  logic [2:0]           res_funct3_i,
  input  logic                 res_pred_taken_i,
  input  logic                 zero_flag_i,
  input  logic                 sign_flag_i,
  input  logic                 carry_flag_i,
  input  logic                 overflow_flag_i,
  output logic                 res_valid_o,
  output logic                 res_taken_o,
  output logic                 res_mispredict_o,
  output logic                 res_illegal_o,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam int                  IDX_W    = idx_width(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(ctr_reset_value(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0]  r_bht [BHT_ENTRIES];

  logic [IDX_W-1:0]     w_res_idx;
  logic [IDX_W-1:0]     w_pred_idx;
  logic                 w_taken;
  logic                 w_illegal;
  logic                 w_update;
  logic                 w_mispredict;
  logic [CTR_BITS-1:0]  w_ctr_cur;
  logic [CTR_BITS-1:0]  w_ctr_next;
  logic [CTR_BITS-1:0]  w_pred_ctr;
  logic                 w_unused_pc;

  logic                 r_pred_valid;
  logic                 r_pred_taken;
  logic                 r_res_valid;
  logic                 r_res_taken;
  logic                 r_res_mispredict;
  logic                 r_res_illegal;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispredict_cnt;

  assign w_res_idx  = res_pc_i[PC_LSB +: IDX_W];
  assign w_pred_idx = pred_pc_i[PC_LSB +: IDX_W];

  // Only the index bits matter; fold the rest away.
  assign w_unused_pc = ^{pred_pc_i, res_pc_i};

  branch_cond_eval u_cond (
    .funct3_i        (res_funct3_i),
    .zero_flag_i     (zero_flag_i),
    .sign_flag_i     (sign_flag_i),
    .carry_flag_i    (carry_flag_i),
    .overflow_flag_i (overflow_flag_i),
    .taken_o         (w_taken),
    .illegal_o       (w_illegal)
  );

  assign w_update     = res_valid_i & ~w_illegal;
  assign w_mispredict = (w_taken != res_pred_taken_i) & ~w_illegal;
  assign w_ctr_cur    = r_bht[w_res_idx];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  // Write-first bypass: a lookup hitting the entry being trained this cycle
  // sees the trained value.
  assign w_pred_ctr = (w_update && (w_res_idx == w_pred_idx)) ? w_ctr_next
                                                              : r_bht[w_pred_idx];

  // NOTE: the table is reset explicitly because predictions after reset must
  // start from weakly-not-taken; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_RST;
    end else if (w_update) begin
      r_bht[w_res_idx] <= w_ctr_next;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pred_valid     <= 1'b0;
      r_pred_taken     <= 1'b0;
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_illegal    <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_pred_valid     <= pred_valid_i;
      r_pred_taken     <= pred_valid_i & w_pred_ctr[CTR_BITS-1];
      r_res_valid      <= res_valid_i;
      r_res_taken      <= res_valid_i & w_taken;
      r_res_mispredict <= res_valid_i & w_mispredict;
      r_res_illegal    <= res_valid_i & w_illegal;
      if (w_update) begin
        r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
        if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign pred_valid_o     = r_pred_valid;
  assign pred_taken_o     = r_pred_taken;
  assign res_valid_o      = r_res_valid;
  assign res_taken_o      = r_res_taken;
  assign res_mispredict_o = r_res_mispredict;
  assign res_illegal_o    = r_res_illegal;
  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_predict
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a behavioural model (integer table of counters, integer
// performance counters wrapping modulo 16).
// -----------------------------------------------------------------------------
module tb_branch_resolve_predict;

  localparam int ENTRIES = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             pred_valid_i;
  logic [31:0]      pred_pc_i;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic             res_valid_i;
  logic [31:0]      res_pc_i;
  logic [2:0]       res_funct3_i;
  logic             res_pred_taken_i;
  logic             zero_flag_i;
  logic             sign_flag_i;
  logic             carry_flag_i;
  logic             overflow_flag_i;
  logic             res_valid_o;
  logic             res_taken_o;
  logic             res_mispredict_o;
  logic             res_illegal_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_bht [ENTRIES];
  int m_branches;
  int m_mispredicts;

  always #5 clk_i = ~clk_i;

  branch_resolve_predict #(
    .BHT_ENTRIES (ENTRIES),
    .CTR_BITS    (2),
    .PC_WIDTH    (32),
    .PC_LSB      (2),
    .CNT_WIDTH   (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_funct3_i     (res_funct3_i),
    .res_pred_taken_i (res_pred_taken_i),
    .zero_flag_i      (zero_flag_i),
    .sign_flag_i      (sign_flag_i),
    .carry_flag_i     (carry_flag_i),
    .overflow_flag_i  (overflow_flag_i),
    .res_valid_o      (res_valid_o),
    .res_taken_o      (res_taken_o),
    .res_mispredict_o (res_mispredict_o),
    .res_illegal_o    (res_illegal_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;  // weakly not taken
    m_branches    = 0;
    m_mispredicts = 0;
  endfunction

  function automatic int model_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  // Architectural meaning of each branch, written from the ISA rules.
  function automatic bit model_taken(input int f3, input bit z, input bit s,
                                     input bit c, input bit v);
    bit less_signed;
    less_signed = (s != v);
    case (f3)
      0:       return z;
      1:       return !z;
      4:       return less_signed;
      5:       return !less_signed;
      6:       return c;
      7:       return !c;
      default: return 0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".pred_valid"}, 32'(pred_valid_o), 0);
    check({tag, ".pred_taken"}, 32'(pred_taken_o), 0);
    check({tag, ".res_valid"},  32'(res_valid_o), 0);
    check({tag, ".res_taken"},  32'(res_taken_o), 0);
    check({tag, ".res_mis"},    32'(res_mispredict_o), 0);
    check({tag, ".res_ill"},    32'(res_illegal_o), 0);
    check({tag, ".br_cnt"},     32'(branch_cnt_o), 0);
    check({tag, ".mis_cnt"},    32'(mispredict_cnt_o), 0);
  endtask

  // One clock: drive inputs, advance the model, clock, compare every output.
  task automatic cycle(input string tag,
                       input bit pv, input logic [31:0] ppc,
                       input bit rv, input logic [31:0] rpc, input int f3,
                       input bit pt, input bit z, input bit s, input bit c, input bit v);
    bit legal, tk;
    bit e_rt, e_mis, e_ill, e_pt;
    int ri;
    pred_valid_i     = pv;
    pred_pc_i        = ppc;
    res_valid_i      = rv;
    res_pc_i         = rpc;
    res_funct3_i     = 3'(f3);
    res_pred_taken_i = pt;
    zero_flag_i      = z;
    sign_flag_i      = s;
    carry_flag_i     = c;
    overflow_flag_i  = v;

    legal = (f3 != 2) && (f3 != 3);
    tk    = model_taken(f3, z, s, c, v);
    e_rt  = rv && tk;
    e_ill = rv && !legal;
    e_mis = rv && legal && (tk != pt);
    if (rv && legal) begin
      ri = model_index(rpc);
      if (tk) m_bht[ri] = (m_bht[ri] < 3) ? m_bht[ri] + 1 : 3;
      else    m_bht[ri] = (m_bht[ri] > 0) ? m_bht[ri] - 1 : 0;
      m_branches = (m_branches + 1) % CNT_MOD;
      if (tk != pt) m_mispredicts = (m_mispredicts + 1) % CNT_MOD;
    end
    // Lookup sees the table after this cycle's training.
    e_pt = pv && (m_bht[model_index(ppc)] >= 2);

    @(posedge clk_i);
    #1;
    check({tag, ".pred_valid"}, 32'(pred_valid_o), 32'(pv));
    check({tag, ".pred_taken"}, 32'(pred_taken_o), 32'(e_pt));
    check({tag, ".res_valid"},  32'(res_valid_o), 32'(rv));
    check({tag, ".res_taken"},  32'(res_taken_o), 32'(e_rt));
    check({tag, ".res_mis"},    32'(res_mispredict_o), 32'(e_mis));
    check({tag, ".res_ill"},    32'(res_illegal_o), 32'(e_ill));
    check({tag, ".br_cnt"},     32'(branch_cnt_o), 32'(m_branches));
    check({tag, ".mis_cnt"},    32'(mispredict_cnt_o), 32'(m_mispredicts));
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    cycle(tag, 1, pc, 0, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input int f3,
                         input bit pt, input bit z, input bit c);
    cycle(tag, 0, 32'h0, 1, pc, f3, pt, z, 0, c, 0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = $urandom;
    // Mostly a handful of hot entries so training and bypass collide often.
    if ($urandom_range(0, 3) != 0) pc[7:2] = 6'($urandom_range(0, 3));
    return pc;
  endfunction

  initial begin
    rst_i = 1'b1;
    pred_valid_i = 0; pred_pc_i = 0; res_valid_i = 0; res_pc_i = 0;
    res_funct3_i = 0; res_pred_taken_i = 0;
    zero_flag_i = 0; sign_flag_i = 0; carry_flag_i = 0; overflow_flag_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Fresh entry predicts not-taken.
    lookup("lkp_fresh", 32'h100);
    // BEQ taken twice with stale not-taken prediction: 01 -> 10 -> 11.
    resolve("beq1", 32'h100, 0, 0, 1, 0);
    resolve("beq2", 32'h100, 0, 0, 1, 0);
    lookup("lkp_trained", 32'h100);

    // Saturation on 0x40.
    for (int i = 0; i < 4; i++) resolve("sat_up", 32'h40, 0, 1, 1, 0);
    resolve("sat_dn1", 32'h40, 0, 1, 0, 0);
    lookup("lkp_sat10", 32'h40);
    for (int i = 0; i < 4; i++) resolve("sat_dn", 32'h40, 0, 0, 0, 0);
    lookup("lkp_sat00", 32'h40);

    // Same-cycle bypass and index independence.
    cycle("byp_same", 1, 32'h200, 1, 32'h200, 6, 0, 0, 0, 1, 0);
    cycle("byp_diff", 1, 32'h204, 1, 32'h200, 6, 1, 0, 0, 1, 0);

    // Illegal encodings: no training, no counting.
    cycle("ill_010", 1, 32'h300, 1, 32'h300, 2, 1, 1, 1, 1, 1);
    cycle("ill_011", 1, 32'h300, 1, 32'h300, 3, 0, 1, 0, 1, 0);
    lookup("lkp_ill", 32'h300);

    // Random traffic; long enough for the 4-bit counters to wrap repeatedly.
    for (int n = 0; n < 1500; n++) begin
      cycle("rnd", bit'($urandom_range(0, 1)), rand_pc(),
            bit'($urandom_range(0, 3) != 0), rand_pc(), $urandom_range(0, 7),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
    end

    // Mid-stream asynchronous reset: outputs clear without a clock edge.
    pred_valid_i = 1; pred_pc_i = 32'h100; res_valid_i = 1; res_pc_i = 32'h100;
    res_funct3_i = 3'b001; res_pred_taken_i = 0; zero_flag_i = 0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    // No pulse after release, and the table is back to weakly-not-taken.
    cycle("post_rst_idle", 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    lookup("post_rst_lkp", 32'h100);
    lookup("post_rst_lkp40", 32'h40);

    // Exactly 17 legal resolves from zero: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) resolve("wrap", 32'h80 + 32'(4 * (i % 3)), 5, 1, 0, 0);
    check("wrap_final", 32'(branch_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
Next-generation branch unit. It evaluates RV32 conditional-branch outcomes from ALU flags and keeps a parametrised bimodal branch history table (BHT) of saturating counters. It serves a registered prediction lookup for fetch and flags mispredictions at resolve. Sits between execute (flags, funct3) and fetch/PC-select; also exposes wrap-around performance counters.

Parameters:
BHT_ENTRIES, 64, number of table entries; power of two, at least 2.
CTR_BITS, 2, width of each saturating counter; at least 1.
PC_WIDTH, 32, width of PC inputs.
PC_LSB, 2, lowest PC bit used for the index (word-aligned instructions).
CNT_WIDTH, 32, width of the performance counters.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
pred_valid_i  input  1  fetch lookup request
pred_pc_i  input  PC_WIDTH  fetch PC
pred_valid_o  output  1  lookup result valid, one cycle after request
pred_taken_o  output  1  predicted direction
res_valid_i  input  1  branch resolving in execute this cycle
res_pc_i  input  PC_WIDTH  PC of resolving branch
res_funct3_i  input  3  branch funct3
res_pred_taken_i  input  1  direction fetch used for this branch
zero_flag_i  input  1  ALU zero
sign_flag_i  input  1  ALU sign
carry_flag_i  input  1  ALU borrow (unsigned less-than)
overflow_flag_i  input  1  ALU signed overflow
res_valid_o  output  1  resolve result valid, one cycle after res_valid_i
res_taken_o  output  1  actual direction
res_mispredict_o  output  1  actual direction differs from res_pred_taken_i
res_illegal_o  output  1  funct3 was 010 or 011
branch_cnt_o  output  CNT_WIDTH  legal resolved branches
mispredict_cnt_o  output  CNT_WIDTH  legal mispredicted branches

Behaviour:
- Clock is clk_i. Reset rst_i is asynchronous and active-high.
- Reset clears every output register and both performance counters to 0. Every BHT counter resets to weakly-not-taken, value 2^(CTR_BITS-1)-1 (01 for 2 bits). Reset asserted mid-operation discards in-flight lookups and resolves; no output pulse follows deassertion.
- Index = pc[PC_LSB +: log2(BHT_ENTRIES)], identical for the predict and resolve paths.
- Branch condition, combinational:
  - 000 (BEQ): taken = zero.
  - 001 (BNE): taken = not zero.
  - 100 (BLT): taken = sign XOR overflow.
  - 101 (BGE): taken = not (sign XOR overflow).
  - 110 (BLTU): taken = carry.
  - 111 (BGEU): taken = not carry.
  - 010 and 011: illegal; taken = 0.
- Resolve path, latency 1 cycle. On the edge where res_valid_i=1:
  - res_valid_o <= 1.
  - res_taken_o <= taken.
  - res_illegal_o <= illegal.
  - res_mispredict_o <= (taken != res_pred_taken_i) and not illegal.
  - With res_valid_i=0, all res_*_o are 0 the next cycle (single-cycle pulses).
- BHT update, same edge, legal resolves only:
  - Taken: counter increments, saturating at 2^CTR_BITS-1.
  - Not taken: counter decrements, saturating at 0.
  - Illegal resolve: no update and no counting.
- Predict path, latency 1 cycle:
  - pred_valid_o <= pred_valid_i.
  - pred_taken_o <= counter MSB of indexed entry; 0 when pred_valid_i=0.
- Same-cycle conflict: a legal resolve and a lookup to the same index read the post-update value (write-first bypass). Different indices are independent.
- Performance counters:
  - branch_cnt_o increments on every legal resolve.
  - mispredict_cnt_o increments on every legal mispredicting resolve.
  - Both wrap modulo 2^CNT_WIDTH.
- Back-to-back resolves every cycle are fully supported. There is no backpressure and no stall.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - Counter reset-value helper and index-width function.
- Sub-module branch_cond_eval: combinational funct3 + flags -> taken, illegal. Reused by any later branch unit.
- Table, bypass and counters stay in the top module.

Test Plan:
- Reset, then lookup pc=0x100 -> next cycle pred_valid_o=1, pred_taken_o=0; branch_cnt_o=0.
- Resolve BEQ pc=0x100, zero=1, pred=0, repeated twice -> res_taken_o=1, res_mispredict_o=1 each time; entry 0x100 goes 01->10->11; later lookup gives pred_taken_o=1; mispredict_cnt_o=2.
- Saturation: 4 taken resolves then 1 not-taken on pc=0x40 -> counter 11, then 10; prediction stays taken. 4 not-taken -> 00, lookup gives 0.
- Same cycle: resolve BLTU pc=0x200, carry=1, with lookup pc=0x200 from reset state -> pred_taken_o=1 (bypassed 10). Lookup pc=0x204 in the same cycle -> pred_taken_o=0.
- Illegal funct3=010 -> res_illegal_o=1, res_taken_o=0, res_mispredict_o=0; counters and BHT unchanged.
- CNT_WIDTH=4: 17 legal resolves -> branch_cnt_o=1. Assert rst_i mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
